// File: rtl/bus_pkg.sv
// Shared types and widths for the program/data memory bus.
// Owner tags travel with reads so data returns to the issuing master.
package bus_pkg;

  localparam int BUS_AW = 12;
  localparam int BUS_DW = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_DMA
  } arb_state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line of owner tags matching the memory read latency.
// Clear empties every stage so dropped reads never report rvalid.
module rd_tag_pipe
  import bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk_i,
  input  logic   clr_i,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= OWN_NONE;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single-port program/data memory.
// Round-robin tie-break plus a hold limit under contention.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW       = BUS_AW,
  parameter int DW       = BUS_DW,
  parameter int MAX_HOLD = 8,
  parameter int READ_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t    state_q, state_d;
  owner_t        last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;

  logic   cpu_iss, dma_iss;
  owner_t push_tag, pop_tag;

  assign cpu_gnt_o = (state_q == ST_CPU);
  assign dma_gnt_o = (state_q == ST_DMA);
  assign busy_o    = (state_q != ST_IDLE);

  assign cpu_iss = cpu_gnt_o & cpu_req_i;
  assign dma_iss = dma_gnt_o & dma_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= OWN_DMA;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i && dma_req_i) begin
          state_d = (last_q == OWN_CPU) ? ST_DMA : ST_CPU;
        end else if (cpu_req_i) begin
          state_d = ST_CPU;
        end else if (dma_req_i) begin
          state_d = ST_DMA;
        end
      end
      ST_CPU: begin
        if (cpu_req_i) begin
          if (dma_req_i && hold_q >= HOLD_LAST) begin
            state_d = ST_DMA;
          end
        end else begin
          state_d = dma_req_i ? ST_DMA : ST_IDLE;
        end
      end
      ST_DMA: begin
        if (dma_req_i) begin
          if (cpu_req_i && hold_q >= HOLD_LAST) begin
            state_d = ST_CPU;
          end
        end else begin
          state_d = cpu_req_i ? ST_CPU : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter only survives while the same owner keeps the bus under contention.
  always_comb begin
    hold_d = '0;
    if (state_d == state_q) begin
      if (cpu_iss && dma_req_i) begin
        hold_d = hold_q + HW'(1);
      end else if (dma_iss && cpu_req_i) begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == ST_CPU) begin
        last_d = OWN_CPU;
      end else if (state_d == ST_DMA) begin
        last_d = OWN_DMA;
      end
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    push_tag    = OWN_NONE;
    if (cpu_gnt_o) begin
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      mem_we_o    = cpu_iss & cpu_we_i;
      if (cpu_iss && !cpu_we_i) begin
        push_tag = OWN_CPU;
      end
    end else if (dma_gnt_o) begin
      mem_addr_o  = dma_addr_i;
      mem_wdata_o = dma_wdata_i;
      mem_we_o    = dma_iss & dma_we_i;
      if (dma_iss && !dma_we_i) begin
        push_tag = OWN_DMA;
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_tags (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .tag_i (push_tag),
    .tag_o (pop_tag)
  );

  // A read maturing in the reset cycle is being dropped too.
  assign cpu_rvalid_o = (pop_tag == OWN_CPU) & ~rst_i;
  assign dma_rvalid_o = (pop_tag == OWN_DMA) & ~rst_i;
  assign rdata_o      = mem_rdata_i;

endmodule
